// File: rtl/tx_iq_unpacker_pkg.sv
// Shared types and constants for the Tx I&Q byte unpacker.
// Byte order: I[23:16], I[15:8], I[7:0], Q[23:16], Q[15:8], Q[7:0].
package tx_iq_pkg;

  localparam int IQ_W             = 24;
  localparam int UCNT_W           = 16;
  localparam int BYTES_PER_SAMPLE = 6;
  localparam int STAGE_W          = 8 * BYTES_PER_SAMPLE;

  localparam logic [2:0] BYTE_I_HI  = 3'd0;
  localparam logic [2:0] BYTE_I_MID = 3'd1;
  localparam logic [2:0] BYTE_I_LO  = 3'd2;
  localparam logic [2:0] BYTE_Q_HI  = 3'd3;
  localparam logic [2:0] BYTE_Q_MID = 3'd4;
  localparam logic [2:0] BYTE_Q_LO  = 3'd5;
  localparam logic [2:0] LAST_BYTE  = BYTE_Q_LO;
  localparam logic [2:0] ISSUE_MAX  = 3'd6;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } fill_state_e;

  function automatic logic [STAGE_W-1:0] put_byte(
    input logic [STAGE_W-1:0] s,
    input logic [2:0]         idx,
    input logic [7:0]         b
  );
    logic [STAGE_W-1:0] r;
    r = s;
    r[STAGE_W-8-8*int'(idx) +: 8] = b;
    return r;
  endfunction

endpackage

// File: rtl/tx_iq_unpacker_if.sv
// FIFO-side and DUC-side signal bundle for the Tx I&Q unpacker.
// slave: the unpacker; master: the FIFO/DUC environment.
interface tx_iq_unpacker_if;
  import tx_iq_pkg::*;

  logic [7:0]      fifo_data;
  logic            fifo_empty;
  logic            fifo_rdreq;
  logic            sample_req;
  logic            run;
  logic            resync;
  logic [IQ_W-1:0] data_out_I;
  logic [IQ_W-1:0] data_out_Q;
  logic            sample_valid;
  logic            underrun;
  logic            assemble_state;

  modport slave (
    input  fifo_data, fifo_empty,
    input  sample_req, run, resync,
    output fifo_rdreq,
    output data_out_I, data_out_Q,
    output sample_valid, underrun,
    output assemble_state
  );

  modport master (
    output fifo_data, fifo_empty,
    output sample_req, run, resync,
    input  fifo_rdreq,
    input  data_out_I, data_out_Q,
    input  sample_valid, underrun,
    input  assemble_state
  );

endinterface

// File: rtl/tx_iq_unpacker_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Holds at all-ones once reached.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (inc_i && (cnt_q != '1))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/tx_iq_unpacker.sv
// Tx FIFO byte stream -> 24-bit I/Q samples, one prefetched sample ahead.
// Optional underrun counter port enabled by TX_UNDERRUN_COUNT_EN.
module tx_iq_unpacker
  import tx_iq_pkg::*;
(
  input  logic clock,
  input  logic reset,
  tx_iq_unpacker_if.slave bus
`ifdef TX_UNDERRUN_COUNT_EN
  ,
  output logic [UCNT_W-1:0] underrun_count
`endif
);

  fill_state_e        state_q, state_d;
  logic [2:0]         issued_q, issued_d;
  logic [2:0]         captured_q, captured_d;
  logic [STAGE_W-1:0] stage_q, stage_d;
  logic [STAGE_W-1:0] stage_cap;
  logic               cap_q;
  logic [IQ_W-1:0]    i_q, i_d, q_q, q_d;
  logic               valid_q, valid_d;
  logic               under_q, under_d;
  logic               asm_q, asm_d;
  logic               rdreq, flush, serve, last;

  assign flush = bus.resync | ~bus.run;
  assign serve = bus.sample_req & ~flush;

  // gated by reset so the read strobe is low while held in reset
  assign rdreq = reset & ~flush & ~bus.fifo_empty &
                 (state_q == FILL) & (issued_q < ISSUE_MAX);

  always_comb begin
    state_d    = state_q;
    issued_d   = issued_q + {2'b00, rdreq};
    captured_d = captured_q;
    stage_d    = stage_q;
    stage_cap  = stage_q;
    i_d        = i_q;
    q_d        = q_q;
    valid_d    = 1'b0;
    under_d    = 1'b0;
    last       = 1'b0;

    if (cap_q) begin
      stage_cap = put_byte(stage_q, captured_q, bus.fifo_data);
      stage_d   = stage_cap;
      if (captured_q == LAST_BYTE) begin
        last    = 1'b1;
        state_d = FULL;
      end else begin
        captured_d = captured_q + 3'd1;
      end
    end

    unique case (1'b1)
      flush: begin
        state_d    = FILL;
        issued_d   = '0;
        captured_d = '0;
        stage_d    = '0;
        if (bus.sample_req) begin
          valid_d = 1'b1;
          i_d     = '0;
          q_d     = '0;
        end
      end
      serve: begin
        valid_d = 1'b1;
        // last covers the request landing on the byte-5 capture cycle
        if ((state_q == FULL) || last) begin
          {i_d, q_d} = stage_cap;
          state_d    = FILL;
          issued_d   = '0;
          captured_d = '0;
          stage_d    = '0;
        end else begin
          i_d     = '0;
          q_d     = '0;
          under_d = 1'b1;
        end
      end
      default: ;
    endcase

    asm_d = (state_d == FILL) & ~flush;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= FILL;
      issued_q   <= '0;
      captured_q <= '0;
      stage_q    <= '0;
      cap_q      <= 1'b0;
      i_q        <= '0;
      q_q        <= '0;
      valid_q    <= 1'b0;
      under_q    <= 1'b0;
      asm_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      issued_q   <= issued_d;
      captured_q <= captured_d;
      stage_q    <= stage_d;
      cap_q      <= rdreq;
      i_q        <= i_d;
      q_q        <= q_d;
      valid_q    <= valid_d;
      under_q    <= under_d;
      asm_q      <= asm_d;
    end
  end

  assign bus.fifo_rdreq     = rdreq;
  assign bus.data_out_I     = i_q;
  assign bus.data_out_Q     = q_q;
  assign bus.sample_valid   = valid_q;
  assign bus.underrun       = under_q;
  assign bus.assemble_state = asm_q;

`ifdef TX_UNDERRUN_COUNT_EN
  sat_counter #(
    .W(UCNT_W)
  ) u_ucnt (
    .clock  (clock),
    .reset  (reset),
    .inc_i  (under_d),
    .clr_i  (bus.resync),
    .count_o(underrun_count)
  );
`else
  // no counter: underrun still pulses on the bus
`endif

endmodule

// File: doc/tx_iq_unpacker.md
# tx_iq_unpacker

Transmit-direction counterpart of the receive I&Q byte packer. Reads bytes from the byte-wide Tx FIFO and reassembles them into one 24-bit I and one 24-bit Q sample per DUC sample request. The Tx FIFO is filled by the Ethernet Tx I&Q stream; the assembled samples feed the DUC/CORDIC. It prefetches one complete sample so a request is always answered with fixed latency, and it substitutes zeros and flags an underrun when data is late.

## Interface
- `IQ_W`, 24: sample width per component; fixed at 3 bytes.
- `UCNT_W`, 16: underrun counter width (used only with the macro).
- `clock` in 1: single clock domain.
- `reset` in 1: asynchronous, active-low.
- `fifo_data` in 8: Tx FIFO q. Valid the cycle after `fifo_rdreq` (normal-mode FIFO, 1-cycle latency).
- `fifo_empty` in 1: Tx FIFO empty.
- `fifo_rdreq` out 1: Tx FIFO read request.
- `sample_req` in 1: single-cycle strobe from the DUC asking for the next sample.
- `run` in 1: transmit enabled; level.
- `resync` in 1: single-cycle; abort the partial sample and realign to byte 0.
- `data_out_I` out 24: I sample, registered.
- `data_out_Q` out 24: Q sample, registered.
- `sample_valid` out 1: one-cycle pulse when `data_out_*` is updated.
- `underrun` out 1: one-cycle pulse when a request is answered with zeros because data was late.
- `assemble_state` out 1: high while waiting for FIFO data with the staging register not full. Used by PureSignal/debug.
- `underrun_count` out `UCNT_W`: present only with `TX_UNDERRUN_COUNT_EN`.

## Operation
- Byte order per sample: I[23:16], I[15:8], I[7:0], Q[23:16], Q[15:8], Q[7:0].
- FSM states:
  - FILL: issue reads and capture bytes.
  - FULL: staging holds 6 bytes; no reads.
- Counters:
  - `issued` (0..6) counts reads issued.
  - `captured` (0..5) is the byte index; the capture cycle is the cycle after the read.
- `fifo_rdreq` = FILL & `run` & !`fifo_empty` & `issued` < 6. Reads may be back-to-back.
- Capture of byte 5 moves the FSM to FULL.
- `sample_req` with FULL: staging is transferred to `data_out_*` and `sample_valid` pulses. Staging and counters clear; the FSM returns to FILL.
- `sample_req` with FILL: `data_out_*` is set to 0, `sample_valid` and `underrun` pulse, and the partial assembly is kept.
- `sample_req` in the same cycle as byte-5 capture: bypass. The completed sample is transferred and there is no underrun.
- `run`=0:
  - No reads; staging and counters clear.
  - `sample_req` answered with zeros plus `sample_valid`, no `underrun`.
- `resync`:
  - Priority over everything.
  - Staging and counters clear, and any in-flight byte returning next cycle is discarded.
  - A coincident `sample_req` is answered with zeros, with no `underrun`.
- Reset: all outputs 0 (`fifo_rdreq`, `data_out_I/Q`, `sample_valid`, `underrun`, `assemble_state`, `underrun_count`). State is FILL, counters are 0.

## Timing
- `sample_req` at cycle t produces `data_out_*` and `sample_valid` at t+1, every case.
- Best-case fill: 6 reads issued t..t+5, bytes captured t+1..t+6, FULL at t+7.
- `sample_req` minimum spacing: 8 cycles. Closer requests are serviced in order by the same rules, and underrun is legal.
- Reset assertion mid-sample takes effect immediately (asynchronous). Deassertion is synchronised externally.

## Configuration
- `TX_UNDERRUN_COUNT_EN` defined:
  - `underrun_count` is a saturating counter, incremented on each `underrun` pulse and held at all-ones.
  - Cleared by reset and `resync`.
- Not defined: the port and counter are absent, and `underrun` still pulses.

## Structure
- Package `tx_iq_pkg`:
  - `BYTES_PER_SAMPLE`=6, `IQ_W`=24.
  - FSM state enum (FILL, FULL).
  - Byte-order constants.
- Sub-module `sat_counter` (width param, inc, clr, saturate) for the underrun counter, instantiated only under the macro.

## Test plan
- FIFO preloaded with 12,34,56,9A,BC,DE and `run`=1; `sample_req` at cycle 20 -> at cycle 21, I=123456, Q=9ABCDE, `sample_valid`=1, `underrun`=0.
- FIFO empty; `sample_req` -> data 0, `sample_valid`=1, `underrun`=1, `underrun_count`=1.
- FIFO receives bytes one per 3 cycles; `sample_req` timed with byte-5 capture -> bypass delivers the full sample, no underrun.
- 3 bytes captured, then `resync`, then 6 new bytes AA..FF -> next sample I=AABBCC, Q=DDEEFF, with no stale bytes.
- `run`=0 with a non-empty FIFO -> `fifo_rdreq` stays 0 and `sample_req` returns zeros with no `underrun`. Asynchronous reset mid-fill -> all outputs 0 immediately.
- 2^16+5 forced underruns with the macro enabled -> `underrun_count` saturates at FFFF.
